// File: rtl/posit_shift_pkg.sv
// Shared definitions for the pipelined log-shifter: operation modes and
// the elaboration-time log2 used to size the shift amount and pipeline depth.
package posit_shift_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } shift_mode_t;

    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One level of the log-shifter: conditionally shifts by 2**LEVEL, accumulates
// the sticky bit and registers the result together with its side-band fields.
module shift_stage
    import posit_shift_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int TAG_W = 4,
    parameter int LEVEL = 0,
    localparam int SHW  = log2(BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             in_valid,
    input  logic [BITS-1:0]  in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_sticky,
    output logic             out_valid,
    output logic [BITS-1:0]  out_data,
    output logic [SHW-1:0]   out_amt,
    output logic [1:0]       out_mode,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sticky
);

    localparam int S = 1 << LEVEL;

    shift_mode_t     mode;
    logic [BITS-1:0] shifted;
    logic            dropped;

    assign mode = shift_mode_t'(in_mode);

    // The MSB is never disturbed by SRA, so it still holds the original sign at every level.
    always_comb begin
        shifted = in_data;
        dropped = 1'b0;
        if (in_amt[LEVEL]) begin
            case (mode)
                MODE_SLL: begin
                    shifted = {in_data[BITS-1-S:0], {S{1'b0}}};
                    dropped = |in_data[BITS-1 -: S];
                end
                MODE_SRL: begin
                    shifted = {{S{1'b0}}, in_data[BITS-1:S]};
                    dropped = |in_data[S-1:0];
                end
                MODE_SRA: begin
                    shifted = {{S{in_data[BITS-1]}}, in_data[BITS-1:S]};
                    dropped = |in_data[S-1:0];
                end
                default: begin
                    shifted = {in_data[BITS-1-S:0], in_data[BITS-1 -: S]};
                    dropped = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_amt    <= '0;
            out_mode   <= '0;
            out_tag    <= '0;
            out_sticky <= 1'b0;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data   <= shifted;
                out_amt    <= in_amt;
                out_mode   <= in_mode;
                out_tag    <= in_tag;
                out_sticky <= in_sticky | dropped;
            end
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Barrel shifter split into log2(BITS) registered levels with a valid/ready
// pipeline that supports full throughput and per-stage backpressure.
module pipelined_shifter
    import posit_shift_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int TAG_W = 4,
    localparam int SHW  = log2(BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_data,
    output logic             out_sticky,
    output logic [TAG_W-1:0] out_tag
);

    // Index 0 is the input side; index k+1 is the register of stage k.
    logic [SHW:0]     valid_s;
    logic [SHW-1:0]   ready_s;
    logic [BITS-1:0]  data_s   [SHW+1];
    logic [SHW-1:0]   amt_s    [SHW+1];
    logic [1:0]       mode_s   [SHW+1];
    logic [TAG_W-1:0] tag_s    [SHW+1];
    logic             sticky_s [SHW+1];

    assign valid_s[0]  = in_valid;
    assign data_s[0]   = in_data;
    assign amt_s[0]    = in_amt;
    assign mode_s[0]   = in_mode;
    assign tag_s[0]    = in_tag;
    assign sticky_s[0] = 1'b0;

    // The chain ready_k = !valid_k || ready_k+1 is unrolled: a stage may load
    // when out_ready is high or any register from it to the output is empty.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        assign ready_s[k] = out_ready | ~(&valid_s[SHW:k+1]);

        shift_stage #(
            .BITS  (BITS),
            .TAG_W (TAG_W),
            .LEVEL (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .load       (ready_s[k]),
            .in_valid   (valid_s[k]),
            .in_data    (data_s[k]),
            .in_amt     (amt_s[k]),
            .in_mode    (mode_s[k]),
            .in_tag     (tag_s[k]),
            .in_sticky  (sticky_s[k]),
            .out_valid  (valid_s[k+1]),
            .out_data   (data_s[k+1]),
            .out_amt    (amt_s[k+1]),
            .out_mode   (mode_s[k+1]),
            .out_tag    (tag_s[k+1]),
            .out_sticky (sticky_s[k+1])
        );
    end

    assign in_ready   = ready_s[0] & ~rst;
    assign out_valid  = valid_s[SHW];
    assign out_data   = data_s[SHW];
    assign out_sticky = sticky_s[SHW];
    assign out_tag    = tag_s[SHW];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench: an 8-bit and a 32-bit shifter checked against a bitwise reference model.
module tb_pipelined_shifter;
    import posit_shift_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sticky;
    logic [7:0] a_in_data, a_out_data;
    logic [2:0] a_in_amt;
    logic [1:0] a_in_mode;
    logic [3:0] a_in_tag, a_out_tag;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sticky;
    logic [31:0] b_in_data, b_out_data;
    logic [4:0]  b_in_amt;
    logic [1:0]  b_in_mode;
    logic [3:0]  b_in_tag, b_out_tag;

    pipelined_shifter #(.BITS(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_amt(a_in_amt), .in_mode(a_in_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_sticky(a_out_sticky), .out_tag(a_out_tag)
    );

    pipelined_shifter #(.BITS(32), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_amt(b_in_amt), .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_sticky(b_out_sticky), .out_tag(b_out_tag)
    );

    typedef struct {
        logic [31:0] data;
        logic        sticky;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   acc_a, acc_b, pop_a, pop_b, lat_check;
    int   pops_b, first_pop_b, last_pop_b;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] d, input int amt, input logic [1:0] mode,
                                   input logic [3:0] tag, input int bits, input int now);
        exp_t e;
        e.data = '0;
        e.sticky = 1'b0;
        e.tag = tag;
        e.cyc = now;
        for (int i = 0; i < bits; i++) begin
            case (mode)
                2'b00: begin
                    e.data[i] = (i >= amt) ? d[i-amt] : 1'b0;
                    if (i >= bits - amt) e.sticky = e.sticky | d[i];
                end
                2'b01: begin
                    e.data[i] = (i + amt < bits) ? d[i+amt] : 1'b0;
                    if (i < amt) e.sticky = e.sticky | d[i];
                end
                2'b10: begin
                    e.data[i] = (i + amt < bits) ? d[i+amt] : d[bits-1];
                    if (i < amt) e.sticky = e.sticky | d[i];
                end
                default: e.data[i] = d[(i - amt + bits) % bits];
            endcase
        end
        return e;
    endfunction

    task automatic popResult(input bit sel, input logic [31:0] data, input logic sticky, input logic [3:0] tag);
        exp_t e;
        if ((sel ? q_b.size() : q_a.size()) == 0) begin
            checkOutput(sel ? "b_unexpected_result" : "a_unexpected_result", 1, 0);
        end else begin
            e = sel ? q_b.pop_front() : q_a.pop_front();
            checkOutput(sel ? "b_data" : "a_data", data, e.data);
            checkOutput(sel ? "b_sticky" : "a_sticky", sticky, e.sticky);
            checkOutput(sel ? "b_tag" : "a_tag", tag, e.tag);
            if (lat_check) checkOutput("latency", cyc - e.cyc, sel ? 5 : 3);
        end
    endtask

    // Handshakes are evaluated at the falling edge and take effect at the next rising edge.
    task automatic cycle();
        @(negedge clk);
        acc_a = 0; acc_b = 0; pop_a = 0; pop_b = 0;
        if (a_in_valid && a_in_ready) begin
            q_a.push_back(model({24'b0, a_in_data}, int'(a_in_amt), a_in_mode, a_in_tag, 8, cyc));
            acc_a = 1;
        end
        if (b_in_valid && b_in_ready) begin
            q_b.push_back(model(b_in_data, int'(b_in_amt), b_in_mode, b_in_tag, 32, cyc));
            acc_b = 1;
        end
        if (a_out_valid && a_out_ready) begin
            pop_a = 1;
            popResult(0, {24'b0, a_out_data}, a_out_sticky, a_out_tag);
        end
        if (b_out_valid && b_out_ready) begin
            pop_b = 1;
            pops_b++;
            if (pops_b == 1) first_pop_b = cyc;
            last_pop_b = cyc;
            popResult(1, b_out_data, b_out_sticky, b_out_tag);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel, input logic [31:0] data, input int amt,
                                 input logic [1:0] mode, input logic [3:0] tag);
        bit done;
        done = 0;
        if (sel) begin
            b_in_valid = 1; b_in_data = data; b_in_amt = amt[4:0]; b_in_mode = mode; b_in_tag = tag;
        end else begin
            a_in_valid = 1; a_in_data = data[7:0]; a_in_amt = amt[2:0]; a_in_mode = mode; a_in_tag = tag;
        end
        for (int i = 0; i < 64 && !done; i++) begin
            cycle();
            done = sel ? acc_b : acc_a;
        end
        if (!done) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (q_a.size() + q_b.size()) > 0; i++) cycle();
        if ((q_a.size() + q_b.size()) > 0) checkOutput("drain_timeout", q_a.size() + q_b.size(), 0);
        repeat (8) cycle();
    endtask

    initial begin
        int c0;
        rst = 1;
        lat_check = 0; pops_b = 0; first_pop_b = 0; last_pop_b = 0;
        a_in_valid = 0; a_in_data = '0; a_in_amt = '0; a_in_mode = '0; a_in_tag = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_in_amt = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1;

        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst_a_in_ready", a_in_ready, 0);
        checkOutput("rst_b_in_ready", b_in_ready, 0);
        checkOutput("rst_out_valid", b_out_valid, 0);
        checkOutput("rst_out_data", b_out_data, 0);
        checkOutput("rst_out_sticky", b_out_sticky, 0);
        checkOutput("rst_out_tag", b_out_tag, 0);
        @(posedge clk);
        #1 rst = 0;
        #2;
        checkOutput("post_rst_a_in_ready", a_in_ready, 1);
        checkOutput("post_rst_b_in_ready", b_in_ready, 1);

        // 8-bit directed cases, first one with latency tracking
        lat_check = 1;
        applyStimulus(0, 32'hB5, 3, MODE_SRL, 4'h1);
        a_in_valid = 0;
        drain();
        lat_check = 0;
        applyStimulus(0, 32'h90, 2, MODE_SRA, 4'h2);
        applyStimulus(0, 32'h81, 1, MODE_SLL, 4'h3);
        applyStimulus(0, 32'h81, 1, MODE_ROL, 4'h4);
        applyStimulus(0, 32'hC3, 7, MODE_SRA, 4'h5);
        applyStimulus(0, 32'h3C, 7, MODE_SLL, 4'h6);
        a_in_valid = 0;
        for (int m = 0; m < 4; m++) applyStimulus(1, 32'hF00D_BEEF, 0, m[1:0], 4'(m + 8));
        b_in_valid = 0;
        drain();

        // Back-to-back SLL stream
        pops_b = 0;
        c0 = cyc;
        for (int i = 0; i < 10; i++) applyStimulus(1, $urandom, i, MODE_SLL, 4'(i));
        b_in_valid = 0;
        checkOutput("b2b_accept_cycles", cyc - c0, 10);
        drain();
        checkOutput("b2b_result_count", pops_b, 10);
        checkOutput("b2b_result_span", last_pop_b - first_pop_b, 9);

        // Full pipeline under backpressure, then simultaneous drain and fill
        b_out_ready = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1, $urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)), 4'(i + 1));
        b_in_valid = 1; b_in_data = 32'h1234_5678; b_in_amt = 5'd4; b_in_mode = MODE_ROL; b_in_tag = 4'h6;
        #2;
        checkOutput("full_in_ready", b_in_ready, 0);
        repeat (3) begin
            cycle();
            checkOutput("stall_no_accept", acc_b, 0);
            checkOutput("stall_out_valid", b_out_valid, 1);
            checkOutput("stall_out_data", b_out_data, q_b[0].data);
            checkOutput("stall_out_sticky", b_out_sticky, q_b[0].sticky);
            checkOutput("stall_out_tag", b_out_tag, q_b[0].tag);
        end
        b_out_ready = 1;
        #2;
        checkOutput("drain_fill_in_ready", b_in_ready, 1);
        cycle();
        checkOutput("drain_fill_accept", acc_b, 1);
        checkOutput("drain_fill_retire", pop_b, 1);
        b_out_ready = 0; b_in_valid = 0;
        #2;
        checkOutput("refull_in_ready", b_in_ready, 0);
        b_out_ready = 1;
        drain();

        // Reset with operations in flight
        for (int i = 0; i < 3; i++) applyStimulus(1, $urandom, 1 + i, MODE_SRL, 4'(i + 1));
        b_in_valid = 0;
        rst = 1;
        #1;
        checkOutput("midrst_out_valid", b_out_valid, 0);
        checkOutput("midrst_in_ready", b_in_ready, 0);
        checkOutput("midrst_out_data", b_out_data, 0);
        q_a.delete();
        q_b.delete();
        cycle();
        cycle();
        rst = 0;
        #2;
        checkOutput("after_rst_in_ready", b_in_ready, 1);
        pops_b = 0;
        applyStimulus(1, 32'h8000_0001, 31, MODE_SRA, 4'hA);
        b_in_valid = 0;
        drain();
        checkOutput("after_rst_results", pops_b, 1);

        // Random traffic with random stalls on both widths
        for (int i = 0; i < 400; i++) begin
            a_in_valid = ($urandom_range(0, 3) != 0);
            a_in_data = 8'($urandom); a_in_amt = 3'($urandom); a_in_mode = 2'($urandom); a_in_tag = 4'($urandom);
            a_out_ready = ($urandom_range(0, 2) != 0);
            b_in_valid = ($urandom_range(0, 3) != 0);
            b_in_data = $urandom; b_in_amt = 5'($urandom); b_in_mode = 2'($urandom); b_in_tag = 4'($urandom);
            b_out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
